gpu_kernel_harness: RTL and testbench

- Self-checking kernel-launch harness around a GPU core.
- Host preloads program memory, data memory, golden image and thread count, then pulses start.
- Block releases the GPU and serves its program/data memory requests until done, then scans data memory against the golden image.
- Reports a return code: 0 = pass.

---
 rtl/gpu_kernel_harness_if.sv | 52 +++++
 rtl/gpu_kernel_harness.sv | 215 +++++++++++++++++++++
 tb/tb_gpu_kernel_harness.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_kernel_harness_if.sv
// GPU-side bundle of the kernel harness: core control plus the
// program-fetch, data-read and data-write request/response channels.
interface gpu_kernel_harness_if #(
    parameter int PROG_ADDR_W = 8,
    parameter int PROG_DATA_W = 16,
    parameter int DATA_ADDR_W = 8,
    parameter int DATA_DATA_W = 8
);
    logic                   gpu_reset;
    logic                   gpu_start;
    logic [7:0]             gpu_thread_count;
    logic                   gpu_done;

    logic                   prog_rd_valid;
    logic [PROG_ADDR_W-1:0] prog_rd_addr;
    logic                   prog_rd_ready;
    logic [PROG_DATA_W-1:0] prog_rd_data;

    logic                   mem_rd_valid;
    logic [DATA_ADDR_W-1:0] mem_rd_addr;
    logic                   mem_rd_ready;
    logic [DATA_DATA_W-1:0] mem_rd_data;

    logic                   mem_wr_valid;
    logic [DATA_ADDR_W-1:0] mem_wr_addr;
    logic [DATA_DATA_W-1:0] mem_wr_data;
    logic                   mem_wr_ready;

    // GPU core side
    modport master (
        input  gpu_reset, gpu_start, gpu_thread_count,
        output gpu_done,
        output prog_rd_valid, prog_rd_addr,
        input  prog_rd_ready, prog_rd_data,
        output mem_rd_valid, mem_rd_addr,
        input  mem_rd_ready, mem_rd_data,
        output mem_wr_valid, mem_wr_addr, mem_wr_data,
        input  mem_wr_ready
    );

    // Harness side
    modport slave (
        output gpu_reset, gpu_start, gpu_thread_count,
        input  gpu_done,
        input  prog_rd_valid, prog_rd_addr,
        output prog_rd_ready, prog_rd_data,
        input  mem_rd_valid, mem_rd_addr,
        output mem_rd_ready, mem_rd_data,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data,
        output mem_wr_ready
    );
endinterface

// File: rtl/gpu_kernel_harness.sv
// Kernel-launch harness: serves GPU program/data memory, then scores data
// against a golden image. Define KERNEL_WATCHDOG_EN for the RUN watchdog.
module gpu_kernel_harness #(
    parameter int PROG_ADDR_W    = 8,
    parameter int PROG_DATA_W    = 16,
    parameter int DATA_ADDR_W    = 8,
    parameter int DATA_DATA_W    = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   host_prog_we,
    input  logic [PROG_ADDR_W-1:0] host_prog_addr,
    input  logic [PROG_DATA_W-1:0] host_prog_wdata,
    input  logic                   host_data_we,
    input  logic                   host_gold_we,
    input  logic [DATA_ADDR_W-1:0] host_data_addr,
    input  logic [DATA_DATA_W-1:0] host_data_wdata,
    input  logic [DATA_ADDR_W:0]   host_gold_len,
    input  logic [7:0]             host_thread_count,
    input  logic                   host_start,

    output logic                   busy,
    output logic                   test_done,
    output logic [7:0]             return_code,

    gpu_kernel_harness_if.slave    gpu
);

    localparam int PROG_DEPTH = 2 ** PROG_ADDR_W;
    localparam int DATA_DEPTH = 2 ** DATA_ADDR_W;
    localparam int LEN_W      = DATA_ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_RUN,
        S_CHECK,
        S_REPORT
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       tc_q, tc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       rc_q, rc_d;

    logic             prog_rdy_q;
    logic             rd_rdy_q;
    logic             wr_rdy_q;
    logic [PROG_DATA_W-1:0] prog_data_q;
    logic [DATA_DATA_W-1:0] rd_data_q;

    logic [PROG_DATA_W-1:0] prog_mem [PROG_DEPTH];
    logic [DATA_DATA_W-1:0] data_mem [DATA_DEPTH];
    logic [DATA_DATA_W-1:0] gold_mem [DATA_DEPTH];

    logic in_idle;
    logic in_run;
    logic prog_acc;
    logic rd_acc;
    logic wr_acc;
    logic mism;
    logic wd_hit;

    assign in_idle = (state_q == S_IDLE);
    assign in_run  = (state_q == S_RUN);

    // A request is taken only when no response is in flight on that port,
    // so a valid still held during the ready cycle is not re-accepted.
    assign prog_acc = in_run && gpu.prog_rd_valid && !prog_rdy_q;
    assign rd_acc   = in_run && gpu.mem_rd_valid  && !rd_rdy_q;
    assign wr_acc   = in_run && gpu.mem_wr_valid  && !wr_rdy_q;

    assign mism = data_mem[idx_q[DATA_ADDR_W-1:0]]
               != gold_mem[idx_q[DATA_ADDR_W-1:0]];

    // Storage has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (in_idle && host_prog_we)
            prog_mem[host_prog_addr] <= host_prog_wdata;
        if (in_idle && host_data_we)
            data_mem[host_data_addr] <= host_data_wdata;
        if (in_idle && host_gold_we)
            gold_mem[host_data_addr] <= host_data_wdata;
        if (wr_acc)
            data_mem[gpu.mem_wr_addr] <= gpu.mem_wr_data;
    end

    // Read data captured on the same edge as a write returns the old word.
    always_ff @(posedge clk) begin
        if (prog_acc)
            prog_data_q <= prog_mem[gpu.prog_rd_addr];
        if (rd_acc)
            rd_data_q <= data_mem[gpu.mem_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_rdy_q <= 1'b0;
            rd_rdy_q   <= 1'b0;
            wr_rdy_q   <= 1'b0;
        end else begin
            prog_rdy_q <= prog_acc;
            rd_rdy_q   <= rd_acc;
            wr_rdy_q   <= wr_acc;
        end
    end

`ifdef KERNEL_WATCHDOG_EN
    logic [31:0] wd_q;

    assign wd_hit = in_run
                 && (wd_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_q <= '0;
        else if (in_run)
            wd_q <= wd_q + 32'd1;
        else
            wd_q <= '0;
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign wd_hit         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tc_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rc_d    = rc_q;
        unique case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    tc_d    = host_thread_count;
                    len_d   = host_gold_len;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                idx_d   = '0;
                err_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (gpu.gpu_done) begin
                    state_d = S_CHECK;
                end else if (wd_hit) begin
                    rc_d    = 8'hFF;
                    state_d = S_REPORT;
                end
            end
            S_CHECK: begin
                if (idx_q == len_q) begin
                    rc_d    = err_q;
                    state_d = S_REPORT;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (mism && err_q != 8'hFE)
                        err_d = err_q + 8'd1;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_RELEASE)
                      || (state_q == S_RUN)
                      || (state_q == S_CHECK);
    assign test_done   = (state_q == S_REPORT);
    assign return_code = rc_q;

    assign gpu.gpu_reset        = !in_run;
    assign gpu.gpu_start        = in_run;
    assign gpu.gpu_thread_count = tc_q;

    assign gpu.prog_rd_ready = prog_rdy_q;
    assign gpu.prog_rd_data  = prog_data_q;
    assign gpu.mem_rd_ready  = rd_rdy_q;
    assign gpu.mem_rd_data   = rd_data_q;
    assign gpu.mem_wr_ready  = wr_rdy_q;

endmodule

// File: tb/tb_gpu_kernel_harness.sv
// Bench for gpu_kernel_harness: a GPU model runs matrix-add kernels while a
// scoreboard checks every response against a reference memory model.
module tb_gpu_kernel_harness;

    localparam int PAW = 8;
    localparam int PDW = 16;
    localparam int DAW = 8;
    localparam int DDW = 8;
    localparam int TO  = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic           host_prog_we      = 1'b0;
    logic [PAW-1:0] host_prog_addr    = '0;
    logic [PDW-1:0] host_prog_wdata   = '0;
    logic           host_data_we      = 1'b0;
    logic           host_gold_we      = 1'b0;
    logic [DAW-1:0] host_data_addr    = '0;
    logic [DDW-1:0] host_data_wdata   = '0;
    logic [DAW:0]   host_gold_len     = '0;
    logic [7:0]     host_thread_count = '0;
    logic           host_start        = 1'b0;
    logic           busy;
    logic           test_done;
    logic [7:0]     return_code;

    gpu_kernel_harness_if #(
        .PROG_ADDR_W(PAW), .PROG_DATA_W(PDW),
        .DATA_ADDR_W(DAW), .DATA_DATA_W(DDW)
    ) gif ();

    gpu_kernel_harness #(
        .PROG_ADDR_W(PAW), .PROG_DATA_W(PDW),
        .DATA_ADDR_W(DAW), .DATA_DATA_W(DDW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .host_prog_we      (host_prog_we),
        .host_prog_addr    (host_prog_addr),
        .host_prog_wdata   (host_prog_wdata),
        .host_data_we      (host_data_we),
        .host_gold_we      (host_gold_we),
        .host_data_addr    (host_data_addr),
        .host_data_wdata   (host_data_wdata),
        .host_gold_len     (host_gold_len),
        .host_thread_count (host_thread_count),
        .host_start        (host_start),
        .busy              (busy),
        .test_done         (test_done),
        .return_code       (return_code),
        .gpu               (gif.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cur_len  = 0;

    logic [15:0] ref_prog [256];
    logic [7:0]  ref_data [256];
    logic [7:0]  ref_gold [256];

    logic [15:0] prog_exp_q [$];
    logic [7:0]  rd_exp_q   [$];
    logic [7:0]  rc_exp_q   [$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected score: mismatching words in the checked window, capped at FE.
    function automatic int model_rc();
        int c = 0;
        for (int i = 0; i < cur_len; i++)
            if (ref_data[i] != ref_gold[i]) c++;
        return (c > 254) ? 254 : c;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (gif.prog_rd_ready === 1'b1) begin
            if (prog_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL prog_rsp unexpected actual=%0h", gif.prog_rd_data);
            end else
                chk("prog_rsp", 32'(gif.prog_rd_data), 32'(prog_exp_q.pop_front()));
        end
        if (gif.mem_rd_ready === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_rsp unexpected actual=%0h", gif.mem_rd_data);
            end else
                chk("rd_rsp", 32'(gif.mem_rd_data), 32'(rd_exp_q.pop_front()));
        end
        if (test_done === 1'b1) begin
            if (rc_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL return_code unexpected actual=%0h", return_code);
            end else
                chk("return_code", 32'(return_code), 32'(rc_exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 program, 1 data, 2 golden
    task automatic hw(input int kind, input int a, input logic [15:0] v);
        host_prog_addr  = PAW'(a);
        host_prog_wdata = v;
        host_data_addr  = DAW'(a);
        host_data_wdata = v[7:0];
        host_prog_we    = (kind == 0);
        host_data_we    = (kind == 1);
        host_gold_we    = (kind == 2);
        tick();
        host_prog_we = 1'b0;
        host_data_we = 1'b0;
        host_gold_we = 1'b0;
        if (kind == 0) ref_prog[a] = v;
        if (kind == 1) ref_data[a] = v[7:0];
        if (kind == 2) ref_gold[a] = v[7:0];
    endtask

    task automatic launch(input int tc, input int len);
        host_thread_count = 8'(tc);
        host_gold_len     = 9'(len);
        cur_len           = len;
        host_start        = 1'b1;
        tick();
        host_start = 1'b0;
        chk("release_busy", 32'(busy), 1);
        chk("release_gpu_reset", 32'(gif.gpu_reset), 1);
        chk("release_gpu_start", 32'(gif.gpu_start), 0);
    endtask

    task automatic wait_start(input int tc);
        for (int n = 0; n < 20; n++) begin
            if (gif.gpu_start === 1'b1) break;
            tick();
        end
        chk("gpu_start_seen", 32'(gif.gpu_start), 1);
        chk("run_gpu_reset", 32'(gif.gpu_reset), 0);
        chk("thread_count", 32'(gif.gpu_thread_count), 32'(tc));
    endtask

    task automatic fetch(input int a);
        gif.prog_rd_valid = 1'b1;
        gif.prog_rd_addr  = PAW'(a);
        prog_exp_q.push_back(ref_prog[a]);
        tick();
        chk("prog_ready_lat", 32'(gif.prog_rd_ready), 1);
        tick();
        chk("prog_ready_once", 32'(gif.prog_rd_ready), 0);
        gif.prog_rd_valid = 1'b0;
    endtask

    task automatic rd(input int a);
        gif.mem_rd_valid = 1'b1;
        gif.mem_rd_addr  = DAW'(a);
        rd_exp_q.push_back(ref_data[a]);
        tick();
        chk("rd_ready_lat", 32'(gif.mem_rd_ready), 1);
        tick();
        chk("rd_ready_once", 32'(gif.mem_rd_ready), 0);
        gif.mem_rd_valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [7:0] v);
        gif.mem_wr_valid = 1'b1;
        gif.mem_wr_addr  = DAW'(a);
        gif.mem_wr_data  = v;
        tick();
        chk("wr_ready_lat", 32'(gif.mem_wr_ready), 1);
        ref_data[a] = v;
        tick();
        chk("wr_ready_once", 32'(gif.mem_wr_ready), 0);
        gif.mem_wr_valid = 1'b0;
    endtask

    task automatic rdwr(input int a, input logic [7:0] v);
        gif.mem_rd_valid = 1'b1;
        gif.mem_rd_addr  = DAW'(a);
        gif.mem_wr_valid = 1'b1;
        gif.mem_wr_addr  = DAW'(a);
        gif.mem_wr_data  = v;
        rd_exp_q.push_back(ref_data[a]);
        tick();
        chk("rdwr_rd_lat", 32'(gif.mem_rd_ready), 1);
        chk("rdwr_wr_lat", 32'(gif.mem_wr_ready), 1);
        ref_data[a] = v;
        tick();
        chk("rdwr_rd_once", 32'(gif.mem_rd_ready), 0);
        chk("rdwr_wr_once", 32'(gif.mem_wr_ready), 0);
        gif.mem_rd_valid = 1'b0;
        gif.mem_wr_valid = 1'b0;
    endtask

    // Matrix add: c[16+i] = a[i] + b[8+i] for each thread.
    task automatic kernel(input int tc);
        wait_start(tc);
        for (int p = 0; p < 13; p++) fetch(p);
        for (int i = 0; i < tc; i++) begin
            rd(i);
            rd(8 + i);
            wr(16 + i, ref_data[i] + ref_data[8 + i]);
        end
    endtask

    task automatic finish_kernel();
        bit seen = 1'b0;
        gif.gpu_done = 1'b1;
        rc_exp_q.push_back(8'(model_rc()));
        tick();
        gif.gpu_done = 1'b0;
        chk("done_stops_gpu", 32'(gif.gpu_start), 0);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (test_done === 1'b1) begin
                chk("report_busy", 32'(busy), 0);
                chk("report_gpu_reset", 32'(gif.gpu_reset), 1);
                seen = 1'b1;
                break;
            end
        end
        chk("report_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(test_done), 0);
    endtask

    task automatic setup_fixed();
        for (int i = 0; i < 8; i++) begin
            hw(1, i, 16'(i));
            hw(1, 8 + i, 16'(i));
            hw(1, 16 + i, 16'd0);
            hw(2, i, 16'(i));
            hw(2, 8 + i, 16'(i));
            hw(2, 16 + i, 16'(2 * i));
        end
    endtask

    initial begin
        logic [7:0] keep;
        int         tc;

        gif.gpu_done      = 1'b0;
        gif.prog_rd_valid = 1'b0;
        gif.prog_rd_addr  = '0;
        gif.mem_rd_valid  = 1'b0;
        gif.mem_rd_addr   = '0;
        gif.mem_wr_valid  = 1'b0;
        gif.mem_wr_addr   = '0;
        gif.mem_wr_data   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_test_done", 32'(test_done), 0);
        chk("rst_return_code", 32'(return_code), 0);
        chk("rst_gpu_reset", 32'(gif.gpu_reset), 1);
        chk("rst_gpu_start", 32'(gif.gpu_start), 0);
        chk("rst_thread_count", 32'(gif.gpu_thread_count), 0);
        chk("rst_prog_ready", 32'(gif.prog_rd_ready), 0);
        chk("rst_rd_ready", 32'(gif.mem_rd_ready), 0);
        chk("rst_wr_ready", 32'(gif.mem_wr_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) begin
            hw(1, i, 16'd0);
            hw(2, i, 16'd0);
        end
        for (int p = 0; p < 13; p++) hw(0, p, 16'($urandom));

        // Matrix add, plus same-address rd/wr and ignored host traffic
        setup_fixed();
        launch(8, 24);
        kernel(8);
        keep = ref_data[5];
        rdwr(5, keep ^ 8'h5A);
        rd(5);
        wr(5, keep);
        host_prog_addr    = '0;
        host_prog_wdata   = ~ref_prog[0];
        host_data_addr    = 8'd20;
        host_data_wdata   = 8'h77;
        host_prog_we      = 1'b1;
        host_data_we      = 1'b1;
        host_gold_we      = 1'b1;
        host_thread_count = 8'd3;
        host_gold_len     = 9'd1;
        host_start        = 1'b1;
        tick();
        host_prog_we = 1'b0;
        host_data_we = 1'b0;
        host_gold_we = 1'b0;
        host_start   = 1'b0;
        chk("busy_ignore_tc", 32'(gif.gpu_thread_count), 8);
        chk("busy_ignore_busy", 32'(busy), 1);
        fetch(0);
        rd(20);
        finish_kernel();

        // Single golden mismatch
        hw(2, 20, 16'd9);
        launch(8, 24);
        kernel(8);
        finish_kernel();

        // Reset mid-run, then relaunch
        hw(2, 20, 16'd8);
        launch(8, 24);
        wait_start(8);
        fetch(0);
        fetch(1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_gpu_reset", 32'(gif.gpu_reset), 1);
        chk("abort_gpu_start", 32'(gif.gpu_start), 0);
        chk("abort_return_code", 32'(return_code), 0);
        tick();
        rst_n = 1'b1;
        tick();
        launch(8, 24);
        kernel(8);
        finish_kernel();

        // Randomized kernels with random golden corruption
        for (int r = 0; r < 4; r++) begin
            tc = int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) begin
                logic [7:0] a;
                logic [7:0] b;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                hw(1, i, 16'(a));
                hw(1, 8 + i, 16'(b));
                hw(1, 16 + i, 16'd0);
                hw(2, i, 16'(a));
                hw(2, 8 + i, 16'(b));
                hw(2, 16 + i, 16'(8'(a + b)));
            end
            for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
                int ca;
                ca = int'($urandom_range(0, 15 + tc));
                hw(2, ca, 16'(ref_gold[ca] ^ 8'($urandom_range(1, 255))));
            end
            launch(tc, 16 + tc);
            kernel(tc);
            finish_kernel();
        end

        // Full-depth scan with every word wrong saturates the count
        for (int i = 0; i < 256; i++) hw(2, i, 16'(~ref_data[i]));
        launch(0, 256);
        wait_start(0);
        finish_kernel();

        // Zero-length golden window passes despite mismatches
        launch(0, 0);
        wait_start(0);
        finish_kernel();

`ifdef KERNEL_WATCHDOG_EN
        begin
            int run = 0;
            bit seen = 1'b0;
            launch(0, 0);
            wait_start(0);
            rc_exp_q.push_back(8'hFF);
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (gif.gpu_start === 1'b1) run++;
                if (test_done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("wdog_seen", 32'(seen), 1);
            chk("wdog_run_cycles", 32'(run), 32'(TO));
            @(posedge clk);
            #1;
        end
`else
        launch(0, 0);
        wait_start(0);
        repeat (TO + 10) tick();
        chk("no_wdog_busy", 32'(busy), 1);
        chk("no_wdog_start", 32'(gif.gpu_start), 1);
        finish_kernel();
`endif

        tick();
        chk("prog_q_drained", 32'(prog_exp_q.size()), 0);
        chk("rd_q_drained", 32'(rd_exp_q.size()), 0);
        chk("rc_q_drained", 32'(rc_exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
